sensor_conditioner: RTL and testbench



---
 rtl/home_pkg.sv | 22 ++
 rtl/sens_debounce.sv | 50 +++++
 rtl/sensor_conditioner.sv | 136 +++++++++++++
 tb/tb_sensor_conditioner.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/home_pkg.sv
// rtl/home_pkg.sv - shared widths, averaging constants and channel enum for the sensor front end
//   TEMP_W    : temperature code width
//   DB_CNT_W  : debounce counter width
//   AVG_DEPTH : averaging history depth
//   AVG_SHIFT : log2(AVG_DEPTH), the divide applied to the running sum
//   SUM_W     : running-sum width, sized so the sum of AVG_DEPTH samples cannot overflow
package home_pkg;

    localparam int TEMP_W    = 8;
    localparam int DB_CNT_W  = 8;
    localparam int AVG_DEPTH = 4;
    localparam int AVG_SHIFT = 2;
    localparam int SUM_W     = TEMP_W + AVG_SHIFT;

    typedef enum logic [1:0] {
        FRONT  = 2'd0,
        REAR   = 2'd1,
        WINDOW = 2'd2,
        FIRE   = 2'd3
    } sens_ch_e;

endpackage

// File: rtl/sens_debounce.sv
// rtl/sens_debounce.sv - 2-flop synchronizer plus stable-count debouncer for one contact
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   raw  : asynchronous contact input
//   sens : debounced output
//   DB_CNT   : consecutive differing cycles needed to change sens (2..255)
//   FAST_SET : 1 = sens rises immediately on a synchronized 1, only the fall is debounced
module sens_debounce
    import home_pkg::*;
#(
    parameter int DB_CNT   = 16,
    parameter int FAST_SET = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sens
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CNT - 1);

    logic                s1;
    logic                s2;
    logic [DB_CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            sens <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == sens) begin
                // any agreeing cycle throws away progress toward a change
                cnt <= '0;
            end else if ((FAST_SET != 0) && s2) begin
                sens <= 1'b1;
                cnt  <= '0;
            end else if (cnt == CNT_LAST) begin
                sens <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - conditions raw contacts and the temperature bus for the home controller
//   clk, rst                              : system clock, asynchronous active-high reset
//   frontRaw, rearRaw, windowRaw, fireRaw : asynchronous raw contacts
//   tempRaw                               : asynchronous 8-bit temperature code
//   frontSens, rearSens, WindowSens       : debounced contacts
//   fireSens                              : fire contact, immediate rise, debounced fall
//   tempSens                              : sampled temperature (4-sample average when SENSOR_TEMP_AVG_EN is defined)
//   tempValid                             : one-cycle strobe when tempSens is refreshed
//   Build option: SENSOR_TEMP_AVG_EN enables the 4-entry moving-average history.
module sensor_conditioner
    import home_pkg::*;
#(
    parameter int DB_CNT     = 16,
    parameter int SAMPLE_DIV = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frontRaw,
    input  logic              rearRaw,
    input  logic              windowRaw,
    input  logic              fireRaw,
    input  logic [TEMP_W-1:0] tempRaw,
    output logic              frontSens,
    output logic              rearSens,
    output logic              WindowSens,
    output logic              fireSens,
    output logic [TEMP_W-1:0] tempSens,
    output logic              tempValid
);

    // ---------------- binary channels ----------------
    logic [3:0] raw_vec;
    logic [3:0] sens_vec;

    assign raw_vec[FRONT]  = frontRaw;
    assign raw_vec[REAR]   = rearRaw;
    assign raw_vec[WINDOW] = windowRaw;
    assign raw_vec[FIRE]   = fireRaw;

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        sens_debounce #(
            .DB_CNT   (DB_CNT),
            .FAST_SET ((ch == int'(FIRE)) ? 1 : 0)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_vec[ch]),
            .sens (sens_vec[ch])
        );
    end

    assign frontSens  = sens_vec[FRONT];
    assign rearSens   = sens_vec[REAR];
    assign WindowSens = sens_vec[WINDOW];
    assign fireSens   = sens_vec[FIRE];

    // ---------------- temperature path ----------------
    localparam logic [7:0] PSC_LAST = 8'(SAMPLE_DIV - 1);

    logic [TEMP_W-1:0] t1;
    logic [TEMP_W-1:0] t2;
    logic [7:0]        psc;
    logic              pend;
    logic              tick;
    logic              want;
    logic              accept;
    logic [TEMP_W-1:0] new_val;

    assign tick   = (psc == PSC_LAST);
    // a tick arriving while a sample is still pending merges into it
    assign want   = pend | tick;
    // two equal consecutive captures mean the bus was not mid-transition
    assign accept = want & (t1 == t2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t1        <= '0;
            t2        <= '0;
            psc       <= '0;
            pend      <= 1'b0;
            tempValid <= 1'b0;
            tempSens  <= '0;
        end else begin
            t1        <= tempRaw;
            t2        <= t1;
            psc       <= tick ? 8'd0 : psc + 8'd1;
            pend      <= want & ~accept;
            tempValid <= accept;
            if (accept) begin
                tempSens <= new_val;
            end
        end
    end

`ifdef SENSOR_TEMP_AVG_EN
    logic [TEMP_W-1:0] hist [AVG_DEPTH];
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  sum_next;
    logic              fill;

    always_comb begin
        sum_next = sum;
        if (!fill) begin
            // first sample after reset fills every slot, so the average starts at that sample
            sum_next = SUM_W'(t2) << AVG_SHIFT;
        end else begin
            sum_next = sum - SUM_W'(hist[AVG_DEPTH-1]) + SUM_W'(t2);
        end
    end

    assign new_val = sum_next[SUM_W-1:AVG_SHIFT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                hist[i] <= '0;
            end
            sum  <= '0;
            fill <= 1'b0;
        end else if (accept) begin
            sum  <= sum_next;
            fill <= 1'b1;
            for (int i = 0; i < AVG_DEPTH; i++) begin
                if (!fill || i == 0) begin
                    hist[i] <= t2;
                end else begin
                    hist[i] <= hist[i-1];
                end
            end
        end
    end
`else
    assign new_val = t2;
`endif

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - self-checking bench for sensor_conditioner (DB_CNT=16, SAMPLE_DIV=8)
module tb_sensor_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic       frontRaw, rearRaw, windowRaw, fireRaw;
    logic [7:0] tempRaw;
    logic       frontSens, rearSens, WindowSens, fireSens;
    logic [7:0] tempSens;
    logic       tempValid;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    sensor_conditioner #(.DB_CNT(16), .SAMPLE_DIV(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .frontRaw   (frontRaw),
        .rearRaw    (rearRaw),
        .windowRaw  (windowRaw),
        .fireRaw    (fireRaw),
        .tempRaw    (tempRaw),
        .frontSens  (frontSens),
        .rearSens   (rearSens),
        .WindowSens (WindowSens),
        .fireSens   (fireSens),
        .tempSens   (tempSens),
        .tempValid  (tempValid)
    );

    task automatic test_reset();
        rst = 1'b1;
        frontRaw = 0; rearRaw = 0; windowRaw = 0; fireRaw = 0;
        tempRaw = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({frontSens, rearSens, WindowSens, fireSens, tempSens, tempValid} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 0",
                     {frontSens, rearSens, WindowSens, fireSens, tempSens, tempValid});
        end
        rst = 1'b0;
    endtask

    task automatic test_clean_debounce();
        logic e;
        @(negedge clk);
        frontRaw = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            e = (j >= 17);
            n_cmp++;
            if (frontSens !== e) begin
                n_err++;
                $display("FAIL debounce_rise k+%0d: got %b want %b", j, frontSens, e);
            end
        end
        frontRaw = 1'b0;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            e = (j < 17);
            n_cmp++;
            if (frontSens !== e) begin
                n_err++;
                $display("FAIL debounce_fall k+%0d: got %b want %b", j, frontSens, e);
            end
        end
    endtask

    task automatic test_glitch();
        logic e;
        @(negedge clk);
        rearRaw = 1'b1;
        repeat (15) begin
            @(negedge clk);
            n_cmp++;
            if (rearSens !== 1'b0) begin
                n_err++;
                $display("FAIL glitch_burst: got %b want 0", rearSens);
            end
        end
        rearRaw = 1'b0;
        @(negedge clk);
        rearRaw = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            e = (j >= 17);
            n_cmp++;
            if (rearSens !== e) begin
                n_err++;
                $display("FAIL glitch_rerise k+%0d: got %b want %b", j, rearSens, e);
            end
        end
        rearRaw = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_fire();
        logic e;
        @(negedge clk);
        fireRaw = 1'b1;
        for (int j = 0; j <= 18; j++) begin
            @(negedge clk);
            if (j == 0) fireRaw = 1'b0;
            e = (j >= 2 && j <= 17);
            n_cmp++;
            if (fireSens !== e) begin
                n_err++;
                $display("FAIL fire_pulse k+%0d: got %b want %b", j, fireSens, e);
            end
        end
    endtask

    task automatic test_concurrent();
        logic [1:0] e;
        @(negedge clk);
        frontRaw  = 1'b1;
        windowRaw = 1'b1;
        for (int j = 0; j <= 17; j++) begin
            @(negedge clk);
            e = (j >= 17) ? 2'b11 : 2'b00;
            n_cmp++;
            if ({frontSens, WindowSens} !== e) begin
                n_err++;
                $display("FAIL concurrent k+%0d: got %b want %b", j, {frontSens, WindowSens}, e);
            end
        end
        frontRaw  = 1'b0;
        windowRaw = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_temp_stable();
        logic       e;
        logic [7:0] want;
        @(negedge clk);
        rst = 1'b1;
        tempRaw = 8'd100;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(8'd100);
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            e = (j % 8 == 0);
            n_cmp++;
            if (tempValid !== e) begin
                n_err++;
                $display("FAIL temp_stable_valid edge %0d: got %b want %b", j, tempValid, e);
            end
            if (tempValid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL temp_stable_extra edge %0d: got %0d want no pulse", j, tempSens);
                end else begin
                    want = exp_q.pop_front();
                    if (tempSens !== want) begin
                        n_err++;
                        $display("FAIL temp_stable_value edge %0d: got %0d want %0d", j, tempSens, want);
                    end
                end
            end
            if (j == 8) begin
                tempRaw = 8'd200;
`ifdef SENSOR_TEMP_AVG_EN
                exp_q.push_back(8'd125);
                exp_q.push_back(8'd150);
                exp_q.push_back(8'd175);
                exp_q.push_back(8'd200);
`else
                repeat (4) exp_q.push_back(8'd200);
`endif
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL temp_stable_drain: got %0d left want 0", exp_q.size());
        end
    endtask

`ifndef SENSOR_TEMP_AVG_EN
    task automatic test_temp_unstable();
        logic       found;
        logic       e;
        logic [7:0] want;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tempValid) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL temp_anchor_timeout: got no pulse want pulse within 20 cycles");
            return;
        end
        exp_q.delete();
        for (int j = 1; j <= 24; j++) begin
            if (j <= 12) tempRaw = (j % 2 == 1) ? 8'h33 : 8'hCC;
            else         tempRaw = 8'h5A;
            if (j == 13) repeat (3) exp_q.push_back(8'h5A);
            @(negedge clk);
            e = (j == 15 || j == 16 || j == 24);
            n_cmp++;
            if (tempValid !== e) begin
                n_err++;
                $display("FAIL temp_unstable_valid e+%0d: got %b want %b", j, tempValid, e);
            end
            if (tempValid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL temp_unstable_extra e+%0d: got %0d want no pulse", j, tempSens);
                end else begin
                    want = exp_q.pop_front();
                    if (tempSens !== want) begin
                        n_err++;
                        $display("FAIL temp_unstable_value e+%0d: got %h want %h", j, tempSens, want);
                    end
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid();
        frontRaw = 1; rearRaw = 1; windowRaw = 1; fireRaw = 1;
        tempRaw = 8'hFF;
        repeat (25) @(negedge clk);
        n_cmp++;
        if ({frontSens, rearSens, WindowSens, fireSens, tempSens} !== 12'hFFF) begin
            n_err++;
            $display("FAIL premid_outputs: got %h want fff",
                     {frontSens, rearSens, WindowSens, fireSens, tempSens});
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({frontSens, rearSens, WindowSens, fireSens, tempSens, tempValid} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_async: got %b want 0",
                     {frontSens, rearSens, WindowSens, fireSens, tempSens, tempValid});
        end
        repeat (10) begin
            @(negedge clk);
            n_cmp++;
            if ({frontSens, rearSens, WindowSens, fireSens, tempSens, tempValid} !== 13'd0) begin
                n_err++;
                $display("FAIL reset_hold: got %b want 0",
                         {frontSens, rearSens, WindowSens, fireSens, tempSens, tempValid});
            end
        end
        rst = 1'b0;
        frontRaw = 0; rearRaw = 0; windowRaw = 0; fireRaw = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_debounce();
        test_glitch();
        test_fire();
        test_concurrent();
        test_temp_stable();
`ifndef SENSOR_TEMP_AVG_EN
        test_temp_unstable();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
